axis_word_serializer: RTL and testbench
=======================================

AXIS_WORD_SERIALIZER -- requirements
Module: axis_word_serializer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 16, giving the bits per word.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 64, giving the input bus bits; WORDS_PER_BEAT = BUS_WIDTH/WORD_WIDTH, default 4.
REQ-003 The block SHALL elaborate with an error if BUS_WIDTH is not an integer multiple of WORD_WIDTH, or if WORDS_PER_BEAT < 2.
REQ-004 Port aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port areset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port s_valid, input, 1 bit: input beat valid.
REQ-007 Port s_ready, output, 1 bit: block accepts the input beat.
REQ-008 Port s_data, input, WORDS_PER_BEAT x WORD_WIDTH: input words, word 0 in the least significant bits.
REQ-009 Port s_keep, input, WORDS_PER_BEAT: per-word valid mask.
REQ-010 Port s_last, input, 1 bit: final beat of the packet.
REQ-011 Port m_valid, output, 1 bit: output word valid.
REQ-012 Port m_ready, input, 1 bit: downstream accepts the word.
REQ-013 Port m_data, output, WORD_WIDTH: output word.
REQ-014 Port m_keep, output, 1 bit: output word carries data.
REQ-015 Port m_last, output, 1 bit: final word of the packet.

Function
REQ-016 An input handshake SHALL occur when s_valid and s_ready are both high at a rising aclk edge; an output handshake SHALL occur when m_valid and m_ready are both high at a rising aclk edge.
REQ-017 State SHALL be a one-beat holding register (buf_data, remaining-keep mask rem, buf_last) plus a two-state FSM: EMPTY and DRAIN.
REQ-018 EMPTY -> DRAIN SHALL occur on an input handshake, loading buf_data = s_data, rem = s_keep, buf_last = s_last.
REQ-019 In DRAIN, the output SHALL be the word at the lowest set bit of rem; each output handshake SHALL clear that bit.
REQ-020 Kept words SHALL be emitted in ascending index order; words with keep = 0 SHALL be skipped with no output beat and no bubble cycle.
REQ-021 m_valid SHALL be high if and only if the FSM is in DRAIN; m_keep SHALL be 1 for every data word.
REQ-022 m_last SHALL equal buf_last AND (rem has exactly one bit set).
REQ-023 A beat with s_keep = 0 and s_last = 1 SHALL produce exactly one output word: m_data = 0, m_keep = 0, m_last = 1.
REQ-024 A beat with s_keep = 0 and s_last = 0 SHALL be accepted and produce no output; the FSM SHALL remain in EMPTY.
REQ-025 s_ready SHALL be high in EMPTY, and also in DRAIN when the final remaining word is being handshaken in that cycle, so that back-to-back beats have no bubble.
REQ-026 DRAIN -> EMPTY SHALL occur when the final remaining word handshakes and no input handshake occurs in the same cycle; if both occur, the register SHALL reload and the FSM SHALL stay in DRAIN.
REQ-027 Latency SHALL be 1 cycle: the first output word is visible the cycle after its input handshake.
REQ-028 Peak throughput SHALL be one word per cycle.
REQ-029 m_data, m_keep and m_last SHALL be held stable while m_valid is high and m_ready is low.
REQ-030 The block SHALL NOT depend on s_data, s_keep or s_last values in any cycle where s_valid is low.

Reset
REQ-031 Asserting areset SHALL immediately force FSM = EMPTY, rem = 0, buf_last = 0, m_valid = 0, m_last = 0, m_keep = 0 and m_data = 0, independent of aclk.
REQ-032 During reset, s_ready SHALL be 0; it SHALL rise in the first cycle after areset deasserts.
REQ-033 Reset asserted mid-packet SHALL discard the buffered beat; no partial word SHALL be emitted after release.

Verification
REQ-034 Input beat data {3,2,1,0}, keep 1111, last 1, with m_ready held 1 -> outputs 0,1,2,3 on 4 consecutive cycles; m_last only on 3.
REQ-035 Input keep 0101, data {D,C,B,A}, last 1 -> outputs A then C; m_last on C; no bubble between them.
REQ-036 Input beat keep 0000, last 1 -> exactly one output word: m_data 0, m_keep 0, m_last 1.
REQ-037 Source at valid probability 5% and sink at ready probability 20%, stimulus counting 0..201 in 4-word beats with last on the final beat -> sink reads 0..201 in order, a single m_last on 201, and outputs stable while stalled.
REQ-038 Two full beats back-to-back with m_ready = 1 -> 8 words on 8 consecutive cycles; s_ready is high in the 4th cycle of the first beat.
REQ-039 areset pulsed while draining word 1 of 4 -> m_valid drops in the same cycle without waiting for an edge; the next beat after release emits its word 0 first.

Source files
------------

// File: rtl/axis_word_serializer.sv
// AXI-Stream word serializer: breaks one wide input beat into its kept
// words, emitted one per cycle in ascending index order. Empty
// keep-masked words are skipped without bubbles. A last beat with no kept
// words still produces one null word so that the packet boundary is
// preserved.
module axis_word_serializer #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned BUS_WIDTH      = 64,
  localparam int unsigned WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [BUS_WIDTH-1:0]      s_data,
  input  logic [WORDS_PER_BEAT-1:0] s_keep,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WORD_WIDTH-1:0]     m_data,
  output logic                      m_keep,
  output logic                      m_last
);

  if ((BUS_WIDTH % WORD_WIDTH) != 0 || WORDS_PER_BEAT < 2) begin : g_bad_params
    $error("axis_word_serializer: BUS_WIDTH must be a multiple of WORD_WIDTH giving at least 2 words");
  end

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                    state, state_n;
  logic [BUS_WIDTH-1:0]      buf_data;
  logic [WORDS_PER_BEAT-1:0] rem;
  logic [WORDS_PER_BEAT-1:0] rem_cleared;
  logic                      buf_last;
  logic [WORD_WIDTH-1:0]     sel_word;
  logic                      final_word;
  logic                      in_hs;
  logic                      out_hs;

  // Clearing the lowest set bit of rem yields the mask after this pop.
  // It is zero both for a single remaining word and for the null word.
  assign rem_cleared = rem & (rem - WORDS_PER_BEAT'(1));
  assign final_word  = (rem_cleared == '0);

  // Select the word at the lowest set bit of rem.
  // Descending scan: the lowest index is written last and wins.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = WORDS_PER_BEAT; i > 0; i--) begin
      if (rem[i-1]) sel_word = buf_data[(i-1)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  assign m_valid = (state == DRAIN);
  assign m_data  = m_valid ? sel_word : '0;
  assign m_keep  = m_valid && (rem != '0);
  assign m_last  = m_valid && buf_last && final_word;
  assign out_hs  = m_valid && m_ready;
  assign s_ready = !areset && ((state == EMPTY) || (out_hs && final_word));
  assign in_hs   = s_valid && s_ready;

  // Next state: a new beat with anything to emit enters DRAIN, even when it
  // replaces the final word. Otherwise, draining the final word returns to EMPTY.
  always_comb begin
    state_n = state;
    if (in_hs) begin
      state_n = ((s_keep != '0) || s_last) ? DRAIN : EMPTY;
    end else if (out_hs && final_word) begin
      state_n = EMPTY;
    end
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= EMPTY;
    else        state <= state_n;
  end

  // Holding register: load on an input handshake, otherwise retire one word per output handshake.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      buf_data <= '0;
      rem      <= '0;
      buf_last <= 1'b0;
    end else if (in_hs) begin
      buf_data <= s_data;
      rem      <= s_keep;
      buf_last <= s_last;
    end else if (out_hs) begin
      rem <= rem_cleared;
      if (final_word) buf_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_word_serializer.sv
// Self-checking bench for axis_word_serializer with a queue-based packet model.
module tb_axis_word_serializer;

  localparam int unsigned WW = 16;
  localparam int unsigned BW = 64;
  localparam int unsigned NW = BW / WW;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic [NW-1:0] s_keep;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic          m_keep;
  logic          m_last;

  typedef struct {
    logic [WW-1:0] d;
    logic          k;
    logic          l;
  } word_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  axis_word_serializer #(.WORD_WIDTH(WW), .BUS_WIDTH(BW)) dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  always #5 aclk = ~aclk;

  // Expected output words of one accepted beat.
  function automatic void model_beat(input logic [BW-1:0] d, input logic [NW-1:0] k, input logic l);
    int hi = -1;
    word_t w;
    for (int i = 0; i < int'(NW); i++) if (k[i]) hi = i;
    if (hi < 0) begin
      if (l) begin
        w.d = '0; w.k = 1'b0; w.l = 1'b1;
        exp_q.push_back(w);
      end
    end else begin
      for (int i = 0; i < int'(NW); i++) begin
        if (k[i]) begin
          w.d = d[i*WW +: WW]; w.k = 1'b1; w.l = l && (i == hi);
          exp_q.push_back(w);
        end
      end
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
    checks++; if (m_keep !== 1'b0) begin errors++; $display("FAIL reset_m_keep got=%b exp=0", m_keep); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    areset = 1'b0;
    @(negedge aclk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL release_m_valid got=%b exp=0", m_valid); end
    @(negedge aclk);
  endtask

  // One beat with m_ready held high: every expected word on consecutive cycles, then idle.
  task automatic test_single_beat(input logic [BW-1:0] d, input logic [NW-1:0] k, input logic l);
    int    n;
    word_t w;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL beat_s_ready got=%b exp=1", s_ready); end
    model_beat(d, k, l);
    n = exp_q.size();
    @(negedge aclk);
    s_valid = 1'b0; s_data = {$urandom, $urandom}; s_keep = NW'($urandom); s_last = 1'($urandom);
    for (int c = 0; c < n; c++) begin
      #1;
      w = exp_q.pop_front();
      checks++;
      if ({m_valid, m_data, m_keep, m_last} !== {1'b1, w.d, w.k, w.l})
        begin errors++; $display("FAIL beat_word%0d got v=%b d=%h k=%b l=%b exp v=1 d=%h k=%b l=%b",
                                 c, m_valid, m_data, m_keep, m_last, w.d, w.k, w.l); end
      @(negedge aclk);
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL beat_idle_m_valid got=%b exp=0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL beat_idle_s_ready got=%b exp=1", s_ready); end
    @(negedge aclk);
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] d1;
    logic [BW-1:0] d2;
    word_t         w;
    d1 = 64'h0003_0002_0001_0000;
    d2 = {$urandom, $urandom};
    s_valid = 1'b1; s_data = d1; s_keep = '1; s_last = 1'b0; m_ready = 1'b1;
    #1;
    model_beat(d1, '1, 1'b0);
    @(negedge aclk);
    s_data = d2; s_last = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_word%0d got v=%b exp queue nonempty", c, m_valid); end
      else begin
        w = exp_q.pop_front();
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, w.d, w.k, w.l})
          begin errors++; $display("FAIL b2b_word%0d got v=%b d=%h k=%b l=%b exp v=1 d=%h k=%b l=%b",
                                   c, m_valid, m_data, m_keep, m_last, w.d, w.k, w.l); end
      end
      if (c < 4) begin
        checks++;
        if (s_ready !== (c == 3)) begin errors++; $display("FAIL b2b_s_ready_c%0d got=%b exp=%b", c, s_ready, (c == 3)); end
      end
      if (s_valid && s_ready) model_beat(d2, '1, 1'b1);
      @(negedge aclk);
      if (c == 3) s_valid = 1'b0;
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", m_valid); end
    @(negedge aclk);
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] d;
    word_t         w;
    d = {$urandom, $urandom};
    s_valid = 1'b1; s_data = d; s_keep = '1; s_last = 1'b1; m_ready = 1'b1;
    #1;
    model_beat(d, '1, 1'b1);
    @(negedge aclk);
    s_valid = 1'b0;
    #1;
    w = exp_q.pop_front();
    checks++; if (m_data !== w.d) begin errors++; $display("FAIL rmid_word0 got=%h exp=%h", m_data, w.d); end
    @(negedge aclk);
    #1;
    checks++;
    if ({m_valid, m_data} !== {1'b1, exp_q[0].d}) begin errors++; $display("FAIL rmid_word1 got v=%b d=%h exp v=1 d=%h", m_valid, m_data, exp_q[0].d); end
    #1 areset = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_data, m_keep, m_last, s_ready} !== '0)
      begin errors++; $display("FAIL rmid_async got v=%b d=%h k=%b l=%b sr=%b exp all 0", m_valid, m_data, m_keep, m_last, s_ready); end
    #1 areset = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_after got=%b exp=0", m_valid); end
    @(negedge aclk);
    test_single_beat({$urandom, $urandom}, '1, 1'b1);
  endtask

  // Random valid/ready stream, checked against the queue model, including stability under stall.
  task automatic test_random(input int unsigned vp, input int unsigned rp, input bit counting);
    int unsigned   nb;
    int unsigned   b;
    bit            pend;
    bit            prev_stall;
    logic [BW-1:0] bd;
    logic [NW-1:0] bk;
    logic          bl;
    logic [WW-1:0] pd;
    logic          pk;
    logic          pl;
    int            lasts;
    word_t         w;
    nb = counting ? 51 : 40;
    b = 0; pend = 1'b0; prev_stall = 1'b0; lasts = 0;
    pd = '0; pk = 1'b0; pl = 1'b0; bd = '0; bk = '0; bl = 1'b0;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      if (!pend && b < nb && $urandom_range(99) < vp) begin
        if (counting) begin
          for (int i = 0; i < int'(NW); i++) bd[i*WW +: WW] = WW'(b * NW + i);
          bk = (b == nb - 1) ? 4'b0011 : 4'b1111;
          bl = (b == nb - 1);
        end else begin
          bd = {$urandom, $urandom};
          bk = NW'($urandom);
          bl = ($urandom_range(3) == 0) || (b == nb - 1);
        end
        pend = 1'b1;
      end
      if (pend) begin s_valid = 1'b1; s_data = bd; s_keep = bk; s_last = bl; end
      else begin s_valid = 1'b0; s_data = {$urandom, $urandom}; s_keep = NW'($urandom); s_last = 1'($urandom); end
      m_ready = ($urandom_range(99) < rp);
      #1;
      if (prev_stall) begin
        checks++;
        if ({m_valid, m_data, m_keep, m_last} !== {1'b1, pd, pk, pl})
          begin errors++; $display("FAIL rnd_stall got v=%b d=%h k=%b l=%b exp v=1 d=%h k=%b l=%b",
                                   m_valid, m_data, m_keep, m_last, pd, pk, pl); end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra got d=%h exp no word", m_data); end
        else begin
          w = exp_q.pop_front();
          if ({m_data, m_keep, m_last} !== {w.d, w.k, w.l})
            begin errors++; $display("FAIL rnd_word got d=%h k=%b l=%b exp d=%h k=%b l=%b",
                                     m_data, m_keep, m_last, w.d, w.k, w.l); end
        end
        if (m_last) lasts++;
      end
      if (s_valid && s_ready) begin model_beat(bd, bk, bl); b++; pend = 1'b0; end
      prev_stall = m_valid && !m_ready;
      pd = m_data; pk = m_keep; pl = m_last;
      @(negedge aclk);
      if (b == nb && !pend && exp_q.size() == 0) break;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    checks++;
    if (b != nb || exp_q.size() != 0) begin errors++; $display("FAIL rnd_timeout got beats=%0d pending=%0d exp beats=%0d pending=0", b, exp_q.size(), nb); end
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle got=%b exp=0", m_valid); end
    if (counting) begin
      checks++; if (lasts != 1) begin errors++; $display("FAIL rnd_last_count got=%0d exp=1", lasts); end
    end
    exp_q.delete();
    @(negedge aclk);
  endtask

  initial begin
    areset = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    test_single_beat(64'h0003_0002_0001_0000, 4'b1111, 1'b1);
    test_single_beat(64'hDDDD_CCCC_BBBB_AAAA, 4'b0101, 1'b1);
    test_single_beat({$urandom, $urandom}, 4'b0000, 1'b1);
    test_single_beat({$urandom, $urandom}, 4'b0000, 1'b0);
    test_single_beat({$urandom, $urandom}, 4'b1000, 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_random(5, 20, 1'b1);
    test_random(60, 70, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
